bpsk_symbol_serializer: RTL and testbench
=========================================

# bpsk_symbol_serializer

Converts a stream of bytes into a timed BPSK symbol stream at a fixed number of clock cycles per symbol. It sits downstream of the byte source and upstream of the carrier mixer. It produces the per-symbol phase bit and a one-cycle symbol strobe, both generated from an internal cycle counter on the single system clock. It does not use a divided clock. A one-byte holding register lets the source deliver the next byte while the current byte is still shifting out, so back-to-back bytes are gap-free.

## Interface
- SPS, default 10: clock cycles per symbol; legal range 2..65535.
- DIFF, default 1:
  - 1: differential encoding (a data 1 toggles phase, a data 0 holds it).
  - 0: absolute encoding (phase equals the data bit).

Ports (clock and reset first):
- clk  input  1  system clock; all logic on its rising edge.
- rst_n  input  1  synchronous, active-low reset. Sampled on the rising edge of clk; low resets all state.
- data_in  input  8  byte to transmit, sent MSB first.
- data_valid  input  1  data_in is valid.
- data_ready  output  1  block accepts a byte this cycle. Registered; equals "holding register empty".
- phase  output  1  current symbol phase: 0 = +1 carrier, 1 = −1 carrier. Registered.
- sym_strobe  output  1  one-cycle pulse in the first cycle of every transmitted symbol.
- busy  output  1  high while in SEND.

## Operation
- Handshake: a byte is accepted on any rising edge where data_valid and data_ready are both high. data_in must hold while valid is high and ready is low.
- Internal state:
  - 8-bit shift register.
  - 8-bit holding register with a full flag.
  - 3-bit bit index.
  - Cycle counter of width $clog2(SPS), counting 0..SPS−1 and wrapping to 0.
- States:
  - IDLE: counter held at 0, phase holds its last value, busy=0, data_ready=1. An accepted byte loads directly into the shift register, sets bit index to 7, and moves to SEND.
  - SEND: counter advances every cycle.
    - When counter = SPS−1: the next symbol begins. Bit index decrements, or a byte boundary occurs when bit index = 0.
    - A byte accepted in SEND goes into the holding register and sets full, so data_ready drops the next cycle.
- Byte boundary (counter = SPS−1 and bit index = 0):
  - Holding register full: transfer it to the shift register, clear full, set bit index to 7, stay in SEND.
  - Holding register empty and a byte is accepted this same cycle: load that byte directly into the shift register and stay in SEND. The holding register stays empty.
  - Otherwise: go to IDLE.
- Phase update, in the same cycle sym_strobe is high:
  - DIFF=1: phase ← phase XOR bit.
  - DIFF=0: phase ← bit.
- Reset mid-operation: both registers are discarded, the FSM goes to IDLE and all outputs take their reset values. No partial byte completes.

## Timing
- Reset values: phase=0, sym_strobe=0, busy=0, data_ready=0 while rst_n is low. data_ready is 1 in the first cycle after rst_n goes high.
- Latency: byte accepted at edge T from IDLE → busy=1, sym_strobe=1 and phase for bit 7 all valid in cycle T+1.
- Symbol spacing: sym_strobe pulses exactly every SPS cycles while in SEND.
- Per-byte timing: one byte occupies 8·SPS cycles. With the holding register refilled in time, there are zero idle cycles between bytes.
- data_ready:
  - Falls the cycle after a byte is accepted into the holding register.
  - Rises the cycle after the holding register transfers to the shift register.
- End of transmission: after the last byte, busy falls in the cycle after the final symbol's counter = SPS−1. Phase retains the final symbol's value.
- SPS=2 is legal and gives a strobe every other cycle.

## Test plan
- Reset and hold:
  - Stimulus: rst_n low 3 cycles, then high.
  - Response: phase=0, busy=0, sym_strobe=0 during reset; data_ready=1 in cycle 1 after release.
- Single byte, SPS=4, DIFF=0:
  - Stimulus: send 0xA5.
  - Response: phase sequence 1,0,1,0,0,1,0,1, each held 4 cycles; 8 strobes spaced 4 cycles; busy high for 32 cycles, then IDLE.
- Differential encoding, SPS=4, DIFF=1, starting from phase=0:
  - Stimulus: send 0xF0.
  - Response: phase 1,0,1,0,0,0,0,0.
- Back-to-back bytes:
  - Stimulus: 0x00 then 0xFF with data_valid always high.
  - Response: second byte accepted 1 cycle after the first; data_ready=0 until the boundary; 16 strobes with no gap; busy continuous for 16·SPS cycles.
- Boundary-cycle accept:
  - Stimulus: present the second byte exactly on the counter = SPS−1, bit index = 0 cycle of the first byte, with the holding register empty.
  - Response: no gap; the next strobe occurs SPS cycles after the previous one.
- Reset mid-byte:
  - Stimulus: assert rst_n low during symbol 3 of 0x55.
  - Response: the next cycle phase=0 and busy=0; no further strobes; a fresh byte after release starts at bit 7.

Source files
------------

// File: rtl/bpsk_symbol_serializer_if.sv
// Byte-in / symbol-out bus between a byte source and the BPSK symbol serializer.
interface bpsk_symbol_serializer_if;
  logic [7:0] data_in;
  logic       data_valid;
  logic       data_ready;
  logic       phase;
  logic       sym_strobe;
  logic       busy;

  modport master (
    output data_in, data_valid,
    input  data_ready, phase, sym_strobe, busy
  );

  modport slave (
    input  data_in, data_valid,
    output data_ready, phase, sym_strobe, busy
  );
endinterface

// File: rtl/bpsk_symbol_serializer.sv
// Serializes bytes MSB first into BPSK phase symbols of SPS clock cycles each,
// with a one-byte holding register so consecutive bytes stream without gaps.
module bpsk_symbol_serializer #(
  parameter int unsigned SPS  = 10,
  parameter bit          DIFF = 1'b1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  bpsk_symbol_serializer_if.slave   bus
);

  localparam int unsigned CNT_W = (SPS > 1) ? $clog2(SPS) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SPS - 1);

  typedef enum logic {IDLE, SEND} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       idx_q, idx_d;
  logic [7:0]       shift_q, shift_d;
  logic [7:0]       hold_q, hold_d;
  logic             full_q, full_d;
  logic             phase_q, phase_d;
  logic             strobe_q, strobe_d;
  logic             busy_q, busy_d;
  logic             data_ready_q, data_ready_d;

  logic accept;
  logic sym_end;
  logic byte_end;
  logic new_sym;
  logic nbit;

  assign accept   = bus.data_valid & data_ready_q;
  assign sym_end  = (cnt_q == CNT_MAX);
  assign byte_end = sym_end & (idx_q == 3'd0);

  // Next-state, datapath and output decode
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    shift_d  = shift_q;
    hold_d   = hold_q;
    full_d   = full_q;
    phase_d  = phase_q;
    strobe_d = 1'b0;
    new_sym  = 1'b0;
    nbit     = 1'b0;

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (accept) begin
          shift_d = bus.data_in;
          idx_d   = 3'd7;
          nbit    = bus.data_in[7];
          new_sym = 1'b1;
          state_d = SEND;
        end
      end
      SEND: begin
        cnt_d = sym_end ? '0 : CNT_W'(cnt_q + 1'b1);
        if (sym_end) begin
          if (idx_q != 3'd0) begin
            shift_d = {shift_q[6:0], 1'b0};
            idx_d   = idx_q - 3'd1;
            nbit    = shift_q[6];
            new_sym = 1'b1;
          end else if (full_q) begin
            shift_d = hold_q;
            full_d  = 1'b0;
            idx_d   = 3'd7;
            nbit    = hold_q[7];
            new_sym = 1'b1;
          end else if (accept) begin
            // Empty holding register at the boundary: bypass straight to the shifter
            shift_d = bus.data_in;
            idx_d   = 3'd7;
            nbit    = bus.data_in[7];
            new_sym = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
        if (accept && !byte_end) begin
          hold_d = bus.data_in;
          full_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (new_sym) begin
      strobe_d = 1'b1;
      phase_d  = DIFF ? (phase_q ^ nbit) : nbit;
    end

    busy_d       = (state_d == SEND);
    data_ready_d = ~full_d;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      idx_q        <= 3'd0;
      shift_q      <= 8'd0;
      hold_q       <= 8'd0;
      full_q       <= 1'b0;
      phase_q      <= 1'b0;
      strobe_q     <= 1'b0;
      busy_q       <= 1'b0;
      data_ready_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      shift_q      <= shift_d;
      hold_q       <= hold_d;
      full_q       <= full_d;
      phase_q      <= phase_d;
      strobe_q     <= strobe_d;
      busy_q       <= busy_d;
      data_ready_q <= data_ready_d;
    end
  end

  assign bus.data_ready = data_ready_q;
  assign bus.phase      = phase_q;
  assign bus.sym_strobe = strobe_q;
  assign bus.busy       = busy_q;

endmodule

// File: tb/tb_bpsk_symbol_serializer.sv
// Directed bench: absolute SPS=4, differential SPS=4 and absolute SPS=2 instances.
module tb_bpsk_symbol_serializer;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  bpsk_symbol_serializer_if if_abs ();
  bpsk_symbol_serializer_if if_diff ();
  bpsk_symbol_serializer_if if_s2 ();

  bpsk_symbol_serializer #(.SPS(4), .DIFF(1'b0)) u_abs  (.clk(clk), .rst_n(rst_n), .bus(if_abs));
  bpsk_symbol_serializer #(.SPS(4), .DIFF(1'b1)) u_diff (.clk(clk), .rst_n(rst_n), .bus(if_diff));
  bpsk_symbol_serializer #(.SPS(2), .DIFF(1'b0)) u_s2   (.clk(clk), .rst_n(rst_n), .bus(if_s2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp)
      else begin
        n_fail++;
        $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
  endtask

  task automatic drive(input int sel, input logic v, input logic [7:0] d);
    case (sel)
      0:       begin if_abs.data_valid  = v; if_abs.data_in  = d; end
      1:       begin if_diff.data_valid = v; if_diff.data_in = d; end
      default: begin if_s2.data_valid   = v; if_s2.data_in   = d; end
    endcase
  endtask

  // {phase, sym_strobe, busy, data_ready}
  function automatic logic [3:0] outs(input int sel);
    case (sel)
      0:       return {if_abs.phase,  if_abs.sym_strobe,  if_abs.busy,  if_abs.data_ready};
      1:       return {if_diff.phase, if_diff.sym_strobe, if_diff.busy, if_diff.data_ready};
      default: return {if_s2.phase,   if_s2.sym_strobe,   if_s2.busy,   if_s2.data_ready};
    endcase
  endfunction

  task automatic check_outs(input string tag, input int sel,
                            input logic ph, input logic st, input logic bz, input logic rd);
    logic [3:0] o;
    o = outs(sel);
    chk($sformatf("%s.phase", tag),  o[3], ph);
    chk($sformatf("%s.strobe", tag), o[2], st);
    chk($sformatf("%s.busy", tag),   o[1], bz);
    chk($sformatf("%s.ready", tag),  o[0], rd);
  endtask

  // Walks a whole transmission cycle by cycle; ph holds expected phases MSB-first.
  // data_ready is expected low for cycles in [rlo_a, rlo_b); a byte is offered at cycle drv_k.
  task automatic stream(input string tag, input int sel, input int sps, input int nsym,
                        input logic [15:0] ph, input int rlo_a, input int rlo_b,
                        input int drv_k, input logic [7:0] drv_byte);
    int s;
    int c;
    for (int k = 0; k < nsym * sps; k++) begin
      s = k / sps;
      c = k % sps;
      check_outs($sformatf("%s.k%0d", tag, k), sel, ph[15 - s], (c == 0), 1'b1,
                 !(k >= rlo_a && k < rlo_b));
      if (k == drv_k)     drive(sel, 1'b1, drv_byte);
      if (k == drv_k + 1) drive(sel, 1'b0, drv_byte);
      tick();
    end
    check_outs($sformatf("%s.end", tag), sel, ph[16 - nsym], 1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    drive(0, 1'b0, 8'h00);
    drive(1, 1'b0, 8'h00);
    drive(2, 1'b0, 8'h00);

    // Reset and hold
    for (int i = 0; i < 3; i++) begin
      tick();
      check_outs($sformatf("rst%0d", i), 0, 1'b0, 1'b0, 1'b0, 1'b0);
    end
    rst_n = 1'b1;
    tick();
    chk("rel.abs.ready",  if_abs.data_ready,  1'b1);
    chk("rel.diff.ready", if_diff.data_ready, 1'b1);
    chk("rel.s2.ready",   if_s2.data_ready,   1'b1);
    chk("rel.abs.busy",   if_abs.busy,        1'b0);

    // Single byte, absolute
    drive(0, 1'b1, 8'hA5);
    tick();
    drive(0, 1'b0, 8'h00);
    stream("a5", 0, 4, 8, {8'hA5, 8'h00}, 0, 0, -1, 8'h00);

    // Differential 0xF0 from phase 0
    drive(1, 1'b1, 8'hF0);
    tick();
    drive(1, 1'b0, 8'h00);
    stream("f0", 1, 4, 8, {8'hA0, 8'h00}, 0, 0, -1, 8'h00);

    // Back-to-back: valid stays high, second byte lands in the holding register
    tick();
    drive(0, 1'b1, 8'h00);
    tick();
    stream("b2b", 0, 4, 16, 16'h00FF, 1, 32, 0, 8'hFF);

    // Second byte offered exactly on the byte-boundary cycle
    tick();
    drive(0, 1'b1, 8'h81);
    tick();
    drive(0, 1'b0, 8'h00);
    stream("bnd", 0, 4, 16, 16'h813C, 0, 0, 31, 8'h3C);

    // SPS=2
    drive(2, 1'b1, 8'hB4);
    tick();
    drive(2, 1'b0, 8'h00);
    stream("s2", 2, 2, 8, {8'hB4, 8'h00}, 0, 0, -1, 8'h00);

    // Reset during symbol 3 of 0x55
    drive(0, 1'b1, 8'h55);
    tick();
    drive(0, 1'b0, 8'h00);
    for (int k = 0; k < 13; k++) tick();
    chk("mid.pre.phase", if_abs.phase, 1'b1);
    chk("mid.pre.busy",  if_abs.busy,  1'b1);
    rst_n = 1'b0;
    tick();
    check_outs("mid.rst0", 0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    check_outs("mid.rst1", 0, 1'b0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    tick();
    check_outs("mid.rel", 0, 1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    chk("mid.idle.strobe", if_abs.sym_strobe, 1'b0);
    drive(0, 1'b1, 8'hC0);
    tick();
    drive(0, 1'b0, 8'h00);
    stream("c0", 0, 4, 8, {8'hC0, 8'h00}, 0, 0, -1, 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
